// File: rtl/fifo_rd_ctrl.sv
// Read-side consumer for the async FIFO: pops fixed-length bursts (or drains after an idle
// timeout) into a 2-entry output buffer driving a registered valid/ready stream.
// Optional statistics outputs (word_cnt, burst_cnt) are enabled by defining FIFO_RD_CTRL_STATS_EN.
module fifo_rd_ctrl #(
   parameter int unsigned DSIZE     = 8,
   parameter int unsigned ASIZE     = 4,
   parameter int unsigned BURST_LEN = 4,
   parameter int unsigned TMO_CYC   = 64,
   parameter int unsigned TMO_W     = 8
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic             fifo_empty,
   input  logic             fifo_near_empty,
   input  logic [DSIZE-1:0] fifo_rdata,
   output logic             fifo_ren,
   input  logic             flush,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [DSIZE-1:0] out_data,
   output logic             out_last,
`ifdef FIFO_RD_CTRL_STATS_EN
   output logic [15:0]      word_cnt,
   output logic [15:0]      burst_cnt,
`endif
   output logic             busy
);

   localparam logic [ASIZE:0]   BurstLen = (ASIZE+1)'(BURST_LEN);
   localparam logic [ASIZE:0]   RemOne   = (ASIZE+1)'(1);
   localparam bit               TmoEn    = (TMO_CYC != 0);
   localparam logic [TMO_W-1:0] TmoLast  = TmoEn ? TMO_W'(TMO_CYC - 1) : '0;

   typedef enum logic [1:0] {StIdle, StBurst, StDrain} state_e;

   state_e           state_q;
   logic [ASIZE:0]   burst_rem_q;
   logic [TMO_W-1:0] tmo_q;
   logic [1:0]       cnt_q;
   logic [DSIZE-1:0] head_data_q;
   logic             head_last_q;
   logic [DSIZE-1:0] tail_data_q;
   logic             tail_last_q;

   logic pop;
   logic xfer;
   logic last_tag;
   logic go_burst;
   logic go_drain;

   always_comb begin
      pop = rrst_n && !flush && !fifo_empty && !cnt_q[1] &&
            ((state_q == StBurst) || (state_q == StDrain));
      xfer     = (cnt_q != 2'd0) && out_ready;
      last_tag = (state_q == StDrain) || (burst_rem_q == RemOne);
      go_burst = (state_q == StIdle) && !fifo_empty && !fifo_near_empty;
      go_drain = (state_q == StIdle) && !fifo_empty && TmoEn && (tmo_q == TmoLast);
   end

   assign fifo_ren  = pop;
   assign out_valid = (cnt_q != 2'd0);
   assign out_data  = head_data_q;
   assign out_last  = head_last_q;
   assign busy      = (state_q != StIdle) || (cnt_q != 2'd0);

   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         state_q     <= StIdle;
         burst_rem_q <= '0;
         tmo_q       <= '0;
         cnt_q       <= 2'd0;
         head_data_q <= '0;
         head_last_q <= 1'b0;
         tail_data_q <= '0;
         tail_last_q <= 1'b0;
      end else if (flush) begin
         // Buffered words are discarded; the FIFO contents stay for the next burst.
         state_q     <= StIdle;
         burst_rem_q <= '0;
         tmo_q       <= '0;
         cnt_q       <= 2'd0;
      end else begin
         case (state_q)
            StIdle: begin
               if (go_burst) begin
                  state_q     <= StBurst;
                  burst_rem_q <= BurstLen;
               end else if (go_drain) begin
                  state_q <= StDrain;
               end
            end
            StBurst: begin
               if (pop) begin
                  burst_rem_q <= burst_rem_q - RemOne;
                  if (burst_rem_q == RemOne) begin
                     state_q <= StIdle;
                  end
               end
            end
            StDrain: begin
               if (fifo_empty) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase

         // Idle timer only runs while data sits unclaimed in IDLE; it saturates.
         if ((state_q != StIdle) || fifo_empty || go_burst || go_drain) begin
            tmo_q <= '0;
         end else if (tmo_q != '1) begin
            tmo_q <= tmo_q + TMO_W'(1);
         end

         if (pop && ((cnt_q == 2'd0) || xfer)) begin
            head_data_q <= fifo_rdata;
            head_last_q <= last_tag;
         end else if (pop) begin
            tail_data_q <= fifo_rdata;
            tail_last_q <= last_tag;
         end else if (xfer && (cnt_q == 2'd2)) begin
            head_data_q <= tail_data_q;
            head_last_q <= tail_last_q;
         end

         cnt_q <= cnt_q + 2'(pop) - 2'(xfer);
      end
   end

`ifdef FIFO_RD_CTRL_STATS_EN
   always_ff @(posedge rclk) begin
      if (!rrst_n || flush) begin
         word_cnt  <= 16'd0;
         burst_cnt <= 16'd0;
      end else if (xfer) begin
         word_cnt <= word_cnt + 16'd1;
         if (head_last_q) begin
            burst_cnt <= burst_cnt + 16'd1;
         end
      end
   end
`endif

endmodule
